// File: rtl/pwm_multi_gen_if.sv
// Bundles the control inputs and PWM/status outputs of pwm_multi_gen.
//   ena         block enable (low freezes counting and ignores buttons)
//   inc/dec     per-channel raw duty up/down buttons, active-high
//   center_mode 0 = edge-aligned frames, 1 = center-aligned frames
//   pwm_out     registered per-channel PWM outputs
//   frame_tick  one-cycle pulse marking the frame boundary
//   duty_flat   active duty per channel, channel k at [k*CW +: CW]
// master drives the controls (testbench / host); slave is the generator.
interface pwm_multi_gen_if #(
  parameter int N_CH = 4,
  parameter int CW   = 8
);
  logic                 ena;
  logic [N_CH-1:0]      inc;
  logic [N_CH-1:0]      dec;
  logic                 center_mode;
  logic [N_CH-1:0]      pwm_out;
  logic                 frame_tick;
  logic [N_CH*CW-1:0]   duty_flat;

  modport master (
    output ena, inc, dec, center_mode,
    input  pwm_out, frame_tick, duty_flat
  );

  modport slave (
    input  ena, inc, dec, center_mode,
    output pwm_out, frame_tick, duty_flat
  );
endinterface

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator with button-driven duty control.
// One shared frame counter (edge- or center-aligned) keeps every channel
// phase-aligned. Each channel debounces its inc/dec buttons on a slow
// sample strobe, adjusts a saturating pending duty, and copies it into the
// active duty only at a frame boundary so a frame is never altered mid-way.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  pwm_multi_gen_if.slave (controls in, pwm/tick/duty out)
module pwm_multi_gen #(
  parameter int N_CH      = 4,
  parameter int CW        = 8,
  parameter int PERIOD    = 10,
  parameter int DUTY_INIT = 5,
  parameter int STEP      = 1,
  parameter int DEB_DIV   = 4
) (
  input  logic            clk,
  input  logic            rst,
  pwm_multi_gen_if.slave  bus
);

  localparam int DW = (DEB_DIV > 2) ? $clog2(DEB_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DEB_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

  logic [DW-1:0]        div;
  logic [CW-1:0]        cnt;
  logic                 dir_dn;    // center mode: 1 while counting down
  logic                 center;    // mode latched at frame end
  logic                 tick;
  logic                 slow_en;
  logic                 frame_end;
  logic [N_CH-1:0]      pwm;
  logic [N_CH-1:0][CW-1:0] duty;

  // Divider is frozen with the rest of the block while disabled.
  assign slow_en   = bus.ena && (div == DIV_LAST);
  assign frame_end = center ? (dir_dn && (cnt == '0)) : (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      div    <= '0;
      cnt    <= '0;
      dir_dn <= 1'b0;
      center <= 1'b0;
      tick   <= 1'b0;
    end else if (bus.ena) begin
      div  <= (div == DIV_LAST) ? '0 : div + 1'b1;
      tick <= frame_end;
      if (frame_end) begin
        // Mode changes only here; every frame starts at 0 counting up.
        cnt    <= '0;
        dir_dn <= 1'b0;
        center <= bus.center_mode;
      end else if (!center) begin
        cnt <= cnt + 1'b1;
      end else if (!dir_dn) begin
        // Top of a center frame: hold PERIOD-1 for one cycle while turning.
        if (cnt == CNT_LAST) dir_dn <= 1'b1;
        else                 cnt    <= cnt + 1'b1;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else begin
      tick <= 1'b0;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    pwm_multi_gen_ch #(
      .CW        (CW),
      .PERIOD    (PERIOD),
      .DUTY_INIT (DUTY_INIT),
      .STEP      (STEP)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .ena     (bus.ena),
      .slow_en (slow_en),
      .load    (bus.ena && frame_end),
      .inc_raw (bus.inc[k]),
      .dec_raw (bus.dec[k]),
      .cnt     (cnt),
      .pwm     (pwm[k]),
      .duty    (duty[k])
    );
    assign bus.duty_flat[k*CW +: CW] = duty[k];
  end

  assign bus.pwm_out    = pwm;
  assign bus.frame_tick = tick;

endmodule

// Per-channel slice: button edge detect, saturating pending duty,
// frame-synchronous active duty and the registered PWM compare.
//   slow_en  debounce sample strobe (already gated by ena)
//   load     frame-end strobe: active duty takes the pending value
//   cnt      shared frame counter
module pwm_multi_gen_ch #(
  parameter int CW        = 8,
  parameter int PERIOD    = 10,
  parameter int DUTY_INIT = 5,
  parameter int STEP      = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          slow_en,
  input  logic          load,
  input  logic          inc_raw,
  input  logic          dec_raw,
  input  logic [CW-1:0] cnt,
  output logic          pwm,
  output logic [CW-1:0] duty
);

  localparam logic [CW:0]   STEP_W = (CW+1)'(STEP);
  localparam logic [CW:0]   PER_W  = (CW+1)'(PERIOD);
  localparam logic [CW-1:0] DINIT  = CW'(DUTY_INIT);

  logic [1:0]    s1, s2;    // bit 1 = inc, bit 0 = dec
  logic [1:0]    press;
  logic [CW-1:0] pend;
  logic [CW:0]   sum;
  logic [CW-1:0] inc_sat, dec_sat;

  // A press is a 0->1 change between consecutive slow samples.
  assign press   = s1 & ~s2 & {2{slow_en}};
  // One extra bit so pend+STEP cannot wrap before the clamp.
  assign sum     = {1'b0, pend} + STEP_W;
  assign inc_sat = (sum > PER_W) ? PER_W[CW-1:0] : sum[CW-1:0];
  assign dec_sat = ({1'b0, pend} < STEP_W) ? '0 : pend - STEP_W[CW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      pend <= DINIT;
      duty <= DINIT;
      pwm  <= 1'b0;
    end else begin
      if (slow_en) begin
        s1 <= {inc_raw, dec_raw};
        s2 <= s1;
      end
      // Simultaneous inc and dec cancel out.
      case (press)
        2'b10:   pend <= inc_sat;
        2'b01:   pend <= dec_sat;
        default: ;
      endcase
      if (load) duty <= pend;
      pwm <= ena && (cnt < duty);
    end
  end

endmodule

// File: tb/tb_pwm_multi_gen.sv
// Directed bench for pwm_multi_gen with default parameters
// (4 channels, PERIOD 10, DUTY_INIT 5, STEP 1, DEB_DIV 4).
module tb_pwm_multi_gen;

  localparam int N_CH = 4;
  localparam int CW   = 8;
  localparam int DEB  = 4;

  logic clk = 1'b0;
  logic rst;

  pwm_multi_gen_if #(.N_CH(N_CH), .CW(CW)) bus ();

  pwm_multi_gen #(
    .N_CH(N_CH), .CW(CW), .PERIOD(10), .DUTY_INIT(5), .STEP(1), .DEB_DIV(DEB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int hi [N_CH];
  int pat3;
  int n;
  logic trk;
  logic [N_CH*CW-1:0] prev_duty;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample 1 ns after the edge. Active duty may only
  // change on a cycle where frame_tick is high.
  task automatic step();
    @(posedge clk);
    #1;
    if (trk && (bus.duty_flat !== prev_duty))
      chk("duty_change_on_tick", int'(bus.frame_tick), 1);
    prev_duty = bus.duty_flat;
  endtask

  task automatic wait_tick(output int cyc);
    cyc = 0;
    while (bus.frame_tick !== 1'b1 && cyc < 100) begin
      step();
      cyc++;
    end
    chk("tick_seen", int'(bus.frame_tick), 1);
  endtask

  // Count pwm highs over the frame following a tick; the frame must end
  // with exactly one tick on its last cycle.
  task automatic measure(input int len);
    int early;
    int c;
    wait_tick(c);
    early = 0;
    pat3  = 0;
    for (int k = 0; k < N_CH; k++) hi[k] = 0;
    for (int i = 1; i <= len; i++) begin
      step();
      for (int k = 0; k < N_CH; k++) hi[k] += int'(bus.pwm_out[k]);
      if (bus.pwm_out[3]) pat3 |= (1 << (i - 1));
      if (i < len && bus.frame_tick) early++;
    end
    chk("tick_early", early, 0);
    chk("tick_period_end", int'(bus.frame_tick), 1);
  endtask

  // One debounced press: 2 samples high then 2 samples low.
  task automatic press(input logic [N_CH-1:0] im, input logic [N_CH-1:0] dm);
    bus.inc = im;
    bus.dec = dm;
    repeat (2*DEB) step();
    bus.inc = '0;
    bus.dec = '0;
    repeat (2*DEB) step();
  endtask

  initial begin
    trk             = 1'b0;
    prev_duty       = '0;
    rst             = 1'b1;
    bus.ena         = 1'b1;
    bus.inc         = '0;
    bus.dec         = '0;
    bus.center_mode = 1'b0;
    repeat (3) step();

    // Reset state
    chk("rst_pwm",  int'(bus.pwm_out), 0);
    chk("rst_tick", int'(bus.frame_tick), 0);
    chk("rst_duty", int'(bus.duty_flat), 32'h05050505);

    // Defaults, edge mode: counter 0 on the first cycle after reset,
    // reaches 9 nine cycles later, tick registered one cycle after that.
    rst = 1'b0;
    trk = 1'b1;
    wait_tick(n);
    chk("first_tick_latency", n, 10);
    measure(10);
    for (int k = 0; k < N_CH; k++) chk("edge_default_high", hi[k], 5);
    chk("edge_default_duty", int'(bus.duty_flat), 32'h05050505);

    // Long hold of inc[0] gives exactly one step.
    bus.inc = 4'b0001;
    repeat (3*DEB) step();
    bus.inc = '0;
    repeat (2*DEB) step();
    measure(10);
    chk("inc0_high", hi[0], 6);
    chk("inc0_others", hi[1] + hi[2] + hi[3], 15);
    chk("inc0_duty", int'(bus.duty_flat), 32'h05050506);

    // Saturation: inc[1] x7 -> 10, dec[2] x6 -> 0.
    for (int p = 0; p < 7; p++) press(4'b0010, (p < 6) ? 4'b0100 : 4'b0000);
    measure(10);
    chk("sat_hi_ch1", hi[1], 10);
    chk("sat_lo_ch2", hi[2], 0);
    chk("sat_duty", int'(bus.duty_flat), 32'h05000A06);
    press(4'b0010, 4'b0100);
    measure(10);
    chk("sat_hold_duty", int'(bus.duty_flat), 32'h05000A06);

    // inc and dec rising together cancel.
    press(4'b1000, 4'b1000);
    measure(10);
    chk("both_high_ch3", hi[3], 5);
    chk("both_duty", int'(bus.duty_flat), 32'h05000A06);

    // Center mode requested mid-frame: current edge frame finishes first.
    step(); step(); step();
    bus.center_mode = 1'b1;
    wait_tick(n);
    chk("mode_deferred", n, 7);
    measure(20);
    chk("ctr_pattern_ch3", pat3, 32'h000F801F);
    chk("ctr_high_ch0", hi[0], 12);
    chk("ctr_high_ch1", hi[1], 20);
    chk("ctr_high_ch2", hi[2], 0);
    chk("ctr_high_ch3", hi[3], 10);

    // Disable for 7 cycles mid-frame, with a button press that must be ignored.
    repeat (4) step();
    bus.ena = 1'b0;
    bus.inc = 4'b0001;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("dis_pwm", int'(bus.pwm_out), 0);
      chk("dis_tick", int'(bus.frame_tick), 0);
    end
    bus.inc = '0;
    bus.ena = 1'b1;
    // Frozen at count 4: 16 cycles remain to the tick, same as if undisturbed.
    wait_tick(n);
    chk("dis_resume", n, 16);
    chk("dis_duty", int'(bus.duty_flat), 32'h05000A06);

    // Reset mid-frame.
    repeat (3) step();
    bus.center_mode = 1'b0;
    trk = 1'b0;
    rst = 1'b1;
    step();
    chk("rst2_pwm",  int'(bus.pwm_out), 0);
    chk("rst2_tick", int'(bus.frame_tick), 0);
    chk("rst2_duty", int'(bus.duty_flat), 32'h05050505);
    rst = 1'b0;
    trk = 1'b1;
    wait_tick(n);
    chk("rst2_first_tick", n, 10);
    measure(10);
    for (int k = 0; k < N_CH; k++) chk("rst2_high", hi[k], 5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
